// File: rtl/sync_frame_tx.sv
// Serial frame transmitter: sync pattern, MSB-first payload, optional even parity,
// then an idle-high guard gap. The line idles high so a 00100 detector cannot fire on idle.
module sync_frame_tx #(
    parameter int                 DATA_W    = 8,
    parameter int                 PAT_LEN   = 5,
    parameter logic [PAT_LEN-1:0] PATTERN   = 5'b00100,
    parameter bit                 PARITY_EN = 1'b1,
    parameter int                 GAP_LEN   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready,
    output logic              tx_out,
    output logic              frame_active,
    output logic              done
);

    // state   | meaning
    // S_IDLE  | line high, ready for a frame request
    // S_SYNC  | sync pattern bits on the line
    // S_DATA  | payload bits on the line, MSB first
    // S_PAR   | even-parity bit on the line
    // S_GAP   | idle-high guard bits after the frame
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SYNC = 3'd1,
        S_DATA = 3'd2,
        S_PAR  = 3'd3,
        S_GAP  = 3'd4
    } state_t;

    localparam int MAX_PD  = (PAT_LEN > DATA_W) ? PAT_LEN : DATA_W;
    localparam int MAX_CNT = (MAX_PD > GAP_LEN) ? MAX_PD : GAP_LEN;
    localparam int CNT_W   = (MAX_CNT < 2) ? 1 : $clog2(MAX_CNT);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PAT_LEN-1:0]  pat_q, pat_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                par_q, par_d;
    logic                tx_q, tx_d;
    logic                active_q, active_d;
    logic                done_q, done_d;
    logic                frame_end;

    // Outputs are the values for the bit being loaded now, so they appear one cycle later.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pat_d     = pat_q;
        shift_d   = shift_q;
        par_d     = par_q;
        tx_d      = 1'b1;
        active_d  = 1'b0;
        done_d    = 1'b0;
        frame_end = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_SYNC;
                    cnt_d    = CNT_W'(PAT_LEN - 1);
                    pat_d    = PATTERN << 1;
                    shift_d  = data_in;
                    par_d    = ^data_in;
                    tx_d     = PATTERN[PAT_LEN-1];
                    active_d = 1'b1;
                end
            end
            S_SYNC: begin
                active_d = 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_DATA;
                    cnt_d   = CNT_W'(DATA_W - 1);
                    tx_d    = shift_q[DATA_W-1];
                    shift_d = shift_q << 1;
                    done_d  = (DATA_W == 1) && !PARITY_EN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    tx_d  = pat_q[PAT_LEN-1];
                    pat_d = pat_q << 1;
                end
            end
            S_DATA: begin
                if (cnt_q != '0) begin
                    active_d = 1'b1;
                    cnt_d    = cnt_q - CNT_W'(1);
                    tx_d     = shift_q[DATA_W-1];
                    shift_d  = shift_q << 1;
                    done_d   = (cnt_q == CNT_W'(1)) && !PARITY_EN;
                end else if (PARITY_EN) begin
                    state_d  = S_PAR;
                    active_d = 1'b1;
                    tx_d     = par_q;
                    done_d   = 1'b1;
                end else begin
                    frame_end = 1'b1;
                end
            end
            S_PAR: begin
                frame_end = 1'b1;
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // With no guard gap the line drops straight into IDLE after the last bit.
        if (frame_end) begin
            if (GAP_LEN == 0) begin
                state_d = S_IDLE;
            end else begin
                state_d = S_GAP;
                cnt_d   = CNT_W'(GAP_LEN - 1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            pat_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pat_q    <= pat_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            tx_q     <= tx_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    assign ready        = (state_q == S_IDLE);
    assign tx_out       = tx_q;
    assign frame_active = active_q;
    assign done         = done_q;

endmodule

// File: tb/tb_sync_frame_tx.sv
// Bench for sync_frame_tx: default build plus a no-parity/no-gap build, both
// compared every cycle against a queue of expected line bits built from the frame rules.
module tb_sync_frame_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       start0, start1;
    logic [7:0] data0, data1;
    logic       rdy0, tx0, act0, done0;
    logic       rdy1, tx1, act1, done1;

    always #5 clk = ~clk;

    sync_frame_tx dut0 (
        .clk(clk), .rst(rst), .start(start0), .data_in(data0),
        .ready(rdy0), .tx_out(tx0), .frame_active(act0), .done(done0)
    );

    sync_frame_tx #(.PARITY_EN(1'b0), .GAP_LEN(0)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .data_in(data1),
        .ready(rdy1), .tx_out(tx1), .frame_active(act1), .done(done1)
    );

    typedef struct packed {
        logic tx;
        logic act;
        logic dn;
    } exp_t;

    localparam exp_t IDLE_E = '{tx: 1'b1, act: 1'b0, dn: 1'b0};

    exp_t        q0[$];
    exp_t        q1[$];
    exp_t        cur0, cur1;
    logic        rdy0_exp = 1'b1;
    logic        rdy1_exp = 1'b1;
    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          last_acc = -1;
    int          acc_edge0 = 0;
    bit          chk_period = 1'b0;
    logic [4:0]  win = 5'b11111;
    int          det_count = 0;
    int          det_edge  = -1;
    logic [15:0] log0 = '0;
    logic [15:0] log1 = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic add(input int inst, input logic b, input logic a, input logic dn);
        exp_t e;
        e.tx  = b;
        e.act = a;
        e.dn  = dn;
        if (inst == 0) q0.push_back(e);
        else           q1.push_back(e);
    endtask

    // Frame = sync 00100, payload MSB first, optional parity, then gap ones.
    task automatic push_frame(input int inst, input logic [7:0] d);
        logic [4:0]  pat;
        logic [13:0] bits;
        int          f;
        int          gl;
        pat  = 5'b00100;
        f    = (inst == 0) ? 14 : 13;
        gl   = (inst == 0) ? 2 : 0;
        bits = {pat, d, ^d};
        for (int k = 0; k < f; k++) add(inst, bits[13-k], 1'b1, (k == f - 1));
        for (int k = 0; k < gl; k++) add(inst, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        if (rdy0_exp && start0 && !rst) begin
            push_frame(0, data0);
            if (chk_period && last_acc >= 0) chk("period", 32'(cyc - last_acc), 32'd17);
            last_acc  = cyc;
            acc_edge0 = cyc;
        end
        if (rdy1_exp && start1 && !rst) push_frame(1, data1);
        if (q0.size() > 0) begin cur0 = q0.pop_front(); rdy0_exp = 1'b0; end
        else               begin cur0 = IDLE_E;         rdy0_exp = 1'b1; end
        if (q1.size() > 0) begin cur1 = q1.pop_front(); rdy1_exp = 1'b0; end
        else               begin cur1 = IDLE_E;         rdy1_exp = 1'b1; end
        #1;
        chk("tx0",    32'(tx0),   32'(cur0.tx));
        chk("act0",   32'(act0),  32'(cur0.act));
        chk("done0",  32'(done0), 32'(cur0.dn));
        chk("ready0", 32'(rdy0),  32'(rdy0_exp));
        chk("tx1",    32'(tx1),   32'(cur1.tx));
        chk("act1",   32'(act1),  32'(cur1.act));
        chk("done1",  32'(done1), 32'(cur1.dn));
        chk("ready1", 32'(rdy1),  32'(rdy1_exp));
        win  = {win[3:0], tx0};
        log0 = {log0[14:0], tx0};
        log1 = {log1[14:0], tx1};
        if (win == 5'b00100) begin
            det_count++;
            det_edge = cyc;
        end
    endtask

    initial begin
        rst    = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        data0  = '0;
        data1  = '0;
        #2;
        chk("rst_tx",    32'(tx0),   32'd1);
        chk("rst_ready", 32'(rdy0),  32'd1);
        chk("rst_act",   32'(act0),  32'd0);
        chk("rst_done",  32'(done0), 32'd0);
        @(posedge clk);
        #3 rst = 1'b0;

        // Idle line after reset release.
        repeat (10) step();

        // A5 frame: explicit bit pattern and a single detector hit at cycle T+5.
        det_count = 0;
        start0 = 1'b1;
        data0  = 8'hA5;
        step();
        start0 = 1'b0;
        data0  = 8'h00;
        repeat (13) step();
        chk("a5_bits", 32'(log0[13:0]), 32'(14'b00100101001010));
        repeat (3) step();
        chk("a5_det_count", 32'(det_count), 32'd1);
        chk("a5_det_cycle", 32'(det_edge), 32'(acc_edge0 + 4));

        // FF frame: parity bit must be 0.
        start0 = 1'b1;
        data0  = 8'hFF;
        step();
        start0 = 1'b0;
        repeat (13) step();
        chk("ff_bits", 32'(log0[13:0]), 32'(14'b00100111111110));
        repeat (3) step();

        // start held high with data changing every cycle: frames every 17 cycles.
        chk_period = 1'b1;
        last_acc   = -1;
        start0     = 1'b1;
        for (int i = 0; i < 120; i++) begin
            data0 = 8'($urandom);
            step();
        end
        chk_period = 1'b0;
        start0     = 1'b0;
        repeat (20) step();

        // Reset during cycle T+8 of a frame.
        start0 = 1'b1;
        data0  = 8'($urandom);
        step();
        start0 = 1'b0;
        repeat (7) step();
        #2 rst = 1'b1;
        #1;
        chk("abort_tx",   32'(tx0),   32'd1);
        chk("abort_act",  32'(act0),  32'd0);
        chk("abort_done", 32'(done0), 32'd0);
        q0.delete();
        q1.delete();
        rdy0_exp = 1'b1;
        rdy1_exp = 1'b1;
        repeat (2) step();
        #3 rst = 1'b0;
        step();
        start0 = 1'b1;
        data0  = 8'h3C;
        step();
        start0 = 1'b0;
        repeat (13) step();
        chk("3c_bits", 32'(log0[13:0]), 32'(14'b00100001111000));
        repeat (4) step();

        // No-parity, no-gap build: 13-bit frame, ready right after the last bit.
        start1 = 1'b1;
        data1  = 8'h01;
        step();
        start1 = 1'b0;
        repeat (12) step();
        chk("np_bits", 32'(log1[12:0]), 32'(13'b0010000000001));
        step();
        chk("np_ready", 32'(rdy1), 32'd1);
        repeat (3) step();

        // Random traffic on both builds.
        for (int i = 0; i < 600; i++) begin
            start0 = ($urandom_range(0, 3) == 0);
            start1 = ($urandom_range(0, 2) == 0);
            data0  = 8'($urandom);
            data1  = 8'($urandom);
            step();
        end
        start0 = 1'b0;
        start1 = 1'b0;
        repeat (20) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
